// File: rtl/pack_3d_to_1d_sub_array_stream.sv
// Captures a ROWS x COLS array and streams it element by element in sub-array flat order.
// Optional macro PACK_FLAT_MIRROR_EN adds a packed 1D mirror (flat_out / flat_valid).
module pack_3d_to_1d_sub_array_stream #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int SUB_ROWS  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIT_WIDTH-1:0] in [ROWS][COLS],
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [((ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1)-1:0] out_index
`ifdef PACK_FLAT_MIRROR_EN
    ,
    output logic [ROWS*COLS*BIT_WIDTH-1:0] flat_out,
    output logic                           flat_valid
`endif
);

    localparam int IDX_W = (ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [RW-1:0]    ROW_SUB_LAST  = RW'(SUB_ROWS - 1);
    localparam logic [RW-1:0]    ROW_SUB_FIRST = RW'(SUB_ROWS % ROWS);
    localparam logic [RW-1:0]    ROW_LAST      = RW'(ROWS - 1);
    localparam logic [CW-1:0]    COL_LAST      = CW'(COLS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(ROWS*COLS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state_q, state_d;
    logic [BIT_WIDTH-1:0] data_q [ROWS][COLS];
    logic [BIT_WIDTH-1:0] data_d [ROWS][COLS];
    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic                 trail_q, trail_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 xfer;

`ifdef PACK_FLAT_MIRROR_EN
    logic [ROWS*COLS*BIT_WIDTH-1:0] flat_q, flat_d;
    logic                           flat_valid_q, flat_valid_d;
    assign flat_out   = flat_q;
    assign flat_valid = flat_valid_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == STREAM);
    assign out_last  = out_valid && (idx_q == IDX_LAST);
    assign out_index = idx_q;
    assign out_data  = data_q[row_q][col_q];
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        row_d   = row_q;
        col_d   = col_q;
        trail_d = trail_q;
        idx_d   = idx_q;
`ifdef PACK_FLAT_MIRROR_EN
        flat_d       = flat_q;
        flat_valid_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in;
                    row_d   = '0;
                    col_d   = '0;
                    trail_d = 1'b0;
                    idx_d   = '0;
                    state_d = STREAM;
`ifdef PACK_FLAT_MIRROR_EN
                    flat_d  = '0;
`endif
                end
            end
            STREAM: begin
                if (xfer) begin
`ifdef PACK_FLAT_MIRROR_EN
                    flat_d[idx_q*BIT_WIDTH +: BIT_WIDTH] = out_data;
`endif
                    if (out_last) begin
                        // Cursor parks at the origin so the idle outputs match reset.
                        state_d = IDLE;
                        row_d   = '0;
                        col_d   = '0;
                        trail_d = 1'b0;
                        idx_d   = '0;
`ifdef PACK_FLAT_MIRROR_EN
                        flat_valid_d = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (!trail_q) begin
                            if (row_q == ROW_SUB_LAST) begin
                                if (col_q == COL_LAST) begin
                                    trail_d = 1'b1;
                                    row_d   = ROW_SUB_FIRST;
                                    col_d   = '0;
                                end else begin
                                    row_d = '0;
                                    col_d = col_q + CW'(1);
                                end
                            end else begin
                                row_d = row_q + RW'(1);
                            end
                        end else begin
                            if (row_q == ROW_LAST) begin
                                row_d = ROW_SUB_FIRST;
                                col_d = col_q + CW'(1);
                            end else begin
                                row_d = row_q + RW'(1);
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '{default: '0};
            row_q   <= '0;
            col_q   <= '0;
            trail_q <= 1'b0;
            idx_q   <= '0;
`ifdef PACK_FLAT_MIRROR_EN
            flat_q       <= '0;
            flat_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            row_q   <= row_d;
            col_q   <= col_d;
            trail_q <= trail_d;
            idx_q   <= idx_d;
`ifdef PACK_FLAT_MIRROR_EN
            flat_q       <= flat_d;
            flat_valid_q <= flat_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_pack_3d_to_1d_sub_array_stream.sv
// Scoreboard bench for pack_3d_to_1d_sub_array_stream: one instance with SUB_ROWS=4 and
// one with SUB_ROWS=8 share stimulus; expected streams come from a nested-loop order model.
module tb_pack_3d_to_1d_sub_array_stream;

   localparam int BW   = 8;
   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam int N    = ROWS * COLS;

   typedef struct packed {
      logic [BW-1:0] data;
      logic [5:0]    index;
      logic          last;
   } expT;

   logic          clock = 1'b0;
   logic          resetN;
   logic [BW-1:0] inArr [ROWS][COLS];
   logic          inValid;
   logic          outReady;

   logic          aInReady, aValid, aLast;
   logic [BW-1:0] aData;
   logic [5:0]    aIndex;
   logic          bInReady, bValid, bLast;
   logic [BW-1:0] bData;
   logic [5:0]    bIndex;

`ifdef PACK_FLAT_MIRROR_EN
   logic [N*BW-1:0] aFlatOut, bFlatOut, expFlat;
   logic            aFlatValid, bFlatValid;
   int              flatPulses = 0;
`endif

   expT qa[$];
   expT qb[$];
   int  checks = 0;
   int  errors = 0;
   int  aTransfers = 0;
   bit  aLastDone = 0, bLastDone = 0, aCapSeen = 0, bCapSeen = 0;

   pack_3d_to_1d_sub_array_stream #(.BIT_WIDTH(BW), .ROWS(ROWS), .COLS(COLS), .SUB_ROWS(4)) dutA (
      .clk(clock), .rst_n(resetN), .in(inArr), .in_valid(inValid), .in_ready(aInReady),
      .out_data(aData), .out_valid(aValid), .out_ready(outReady), .out_last(aLast),
      .out_index(aIndex)
`ifdef PACK_FLAT_MIRROR_EN
      , .flat_out(aFlatOut), .flat_valid(aFlatValid)
`endif
   );

   pack_3d_to_1d_sub_array_stream #(.BIT_WIDTH(BW), .ROWS(ROWS), .COLS(COLS), .SUB_ROWS(8)) dutB (
      .clk(clock), .rst_n(resetN), .in(inArr), .in_valid(inValid), .in_ready(bInReady),
      .out_data(bData), .out_valid(bValid), .out_ready(outReady), .out_last(bLast),
      .out_index(bIndex)
`ifdef PACK_FLAT_MIRROR_EN
      , .flat_out(bFlatOut), .flat_valid(bFlatValid)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
      end
   endtask

   // Reference order: leading rows column by column, then trailing rows column by column.
   task automatic pushModel(input int subRows, input bit toB);
      expT e;
      int  k = 0;
      for (int j = 0; j < COLS; j++) begin
         for (int i = 0; i < subRows; i++) begin
            e.data = inArr[i][j]; e.index = 6'(k); e.last = (k == N-1); k++;
            if (toB) qb.push_back(e); else qa.push_back(e);
         end
      end
      for (int j = 0; j < COLS; j++) begin
         for (int i = subRows; i < ROWS; i++) begin
            e.data = inArr[i][j]; e.index = 6'(k); e.last = (k == N-1); k++;
            if (toB) qb.push_back(e); else qa.push_back(e);
         end
      end
   endtask

   task automatic fillArray(input bit usePattern);
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++)
            inArr[i][j] = usePattern ? BW'(16*i + j) : BW'($urandom_range(0, 255));
   endtask

   // Present one array and wait for the capture edge; called and returns at a falling edge.
   task automatic applyStimulus(input bit usePattern);
      int t = 0;
      fillArray(usePattern);
      inValid = 1'b1;
      while (!aInReady && t < 300) begin
         @(negedge clock);
         t++;
      end
      if (!aInReady) checkOutput("capture_timeout_in_ready", aInReady, 1);
      @(negedge clock);
      inValid = 1'b0;
   endtask

   task automatic waitIdle(input int budget, input bit randomReady);
      for (int t = 0; t < budget; t++) begin
         if (qa.size() == 0 && qb.size() == 0 && aInReady && bInReady && !inValid) return;
         if (randomReady) outReady = ($urandom_range(0, 3) != 0);
         @(negedge clock);
      end
      checkOutput("drain_timeout_queue", qa.size() + qb.size(), 0);
      checkOutput("drain_timeout_in_ready", aInReady && bInReady, 1);
   endtask

   task automatic waitIndexA(input int k);
      for (int t = 0; t < 300 && !(aValid && aIndex == 6'(k)); t++) @(negedge clock);
   endtask

   // Monitor: samples just after the falling edge, records captures, scores every output.
   always begin
      expT e;
      @(negedge clock);
      #1;
      if (!resetN) begin
         aLastDone = 0; bLastDone = 0; aCapSeen = 0; bCapSeen = 0;
`ifdef PACK_FLAT_MIRROR_EN
         expFlat = '0;
`endif
      end else begin
`ifdef PACK_FLAT_MIRROR_EN
         checkOutput("a_flat_valid_pulse", aFlatValid, aLastDone);
         checkOutput("b_flat_valid_pulse", bFlatValid, bLastDone);
         if (aFlatValid) begin
            flatPulses++;
            checks++;
            if (aFlatOut !== expFlat) begin
               errors++;
               $display("[TB] FAIL a_flat_out: got %h, expected %h", aFlatOut, expFlat);
            end
         end
`endif
         if (aLastDone) begin
            checkOutput("a_bubble_in_ready", aInReady, 1);
            checkOutput("a_bubble_out_valid", aValid, 0);
         end
         if (bLastDone) begin
            checkOutput("b_bubble_in_ready", bInReady, 1);
            checkOutput("b_bubble_out_valid", bValid, 0);
         end
         if (aCapSeen) checkOutput("a_first_valid_latency", aValid, 1);
         if (bCapSeen) checkOutput("b_first_valid_latency", bValid, 1);
         aLastDone = 0; bLastDone = 0; aCapSeen = 0; bCapSeen = 0;

         checkOutput("a_ready_excl_valid", aInReady ^ aValid, 1);
         checkOutput("b_ready_excl_valid", bInReady ^ bValid, 1);

         if (inValid && aInReady) begin
            pushModel(4, 1'b0);
            aCapSeen = 1;
`ifdef PACK_FLAT_MIRROR_EN
            expFlat = '0;
`endif
         end
         if (inValid && bInReady) begin
            pushModel(8, 1'b1);
            bCapSeen = 1;
         end

         if (aValid) begin
            if (qa.size() == 0) checkOutput("a_spurious_valid", aValid, 0);
            else begin
               e = qa[0];
               checkOutput("a_out_data", aData, e.data);
               checkOutput("a_out_index", aIndex, e.index);
               checkOutput("a_out_last", aLast, e.last);
               if (outReady) begin
                  void'(qa.pop_front());
                  aTransfers++;
                  aLastDone = e.last;
`ifdef PACK_FLAT_MIRROR_EN
                  expFlat[e.index*BW +: BW] = e.data;
`endif
               end
            end
         end
         if (bValid) begin
            if (qb.size() == 0) checkOutput("b_spurious_valid", bValid, 0);
            else begin
               e = qb[0];
               checkOutput("b_out_data", bData, e.data);
               checkOutput("b_out_index", bIndex, e.index);
               checkOutput("b_out_last", bLast, e.last);
               if (outReady) begin
                  void'(qb.pop_front());
                  bLastDone = e.last;
               end
            end
         end
      end
   end

   // Directed scenarios followed by randomized arrays with random backpressure.
   initial begin
      int validCycles;
      int startTransfers;
      resetN = 1'b0; inValid = 1'b0; outReady = 1'b0;
      fillArray(1'b0);
      repeat (3) @(negedge clock);
      checkOutput("reset_in_ready", aInReady, 1);
      checkOutput("reset_out_valid", aValid, 0);
      checkOutput("reset_out_last", aLast, 0);
      checkOutput("reset_out_index", aIndex, 0);
      checkOutput("reset_out_data", aData, 0);
      checkOutput("reset_b_out_data", bData, 0);
      resetN = 1'b1;
      @(negedge clock);

      $display("[TB] full-rate drain of the pattern array");
      outReady = 1'b1;
      applyStimulus(1'b1);
      validCycles = 0;
      for (int t = 0; t < 200 && aValid; t++) begin
         validCycles++;
         @(negedge clock);
      end
      checkOutput("full_rate_valid_cycles", validCycles, N);
      waitIdle(300, 1'b0);

      $display("[TB] stall at index 5");
      startTransfers = aTransfers;
      applyStimulus(1'b1);
      waitIndexA(5);
      outReady = 1'b0;
      for (int s = 0; s < 3; s++) begin
         checkOutput("stall_out_data", aData, 8'h11);
         checkOutput("stall_out_index", aIndex, 5);
         checkOutput("stall_out_valid", aValid, 1);
         @(negedge clock);
      end
      outReady = 1'b1;
      waitIdle(300, 1'b0);
      checkOutput("stall_total_transfers", aTransfers - startTransfers, N);

      $display("[TB] reset at index 20");
      applyStimulus(1'b1);
      waitIndexA(20);
      resetN = 1'b0;
      outReady = 1'b0;
      @(negedge clock);
      qa.delete();
      qb.delete();
      checkOutput("midreset_in_ready", aInReady, 1);
      checkOutput("midreset_out_valid", aValid, 0);
      checkOutput("midreset_out_index", aIndex, 0);
      checkOutput("midreset_out_data", aData, 0);
      checkOutput("midreset_b_out_valid", bValid, 0);
      resetN = 1'b1;
      outReady = 1'b1;
      applyStimulus(1'b0);
      waitIdle(300, 1'b0);

      $display("[TB] in_valid held high with the array changing every cycle");
      inValid = 1'b1;
      for (int t = 0; t < 3*N + 20; t++) begin
         fillArray(1'b0);
         outReady = ($urandom_range(0, 3) != 0);
         @(negedge clock);
      end
      inValid = 1'b0;
      waitIdle(1000, 1'b1);

      $display("[TB] randomized arrays with random backpressure");
      for (int n = 0; n < 4; n++) begin
         outReady = ($urandom_range(0, 1) != 0);
         applyStimulus(1'b0);
         waitIdle(1000, 1'b1);
      end

      outReady = 1'b1;
      repeat (3) @(negedge clock);
      checkOutput("final_queue_a_empty", qa.size(), 0);
      checkOutput("final_queue_b_empty", qb.size(), 0);
`ifdef PACK_FLAT_MIRROR_EN
      checkOutput("flat_pulse_seen", flatPulses > 0, 1);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
